// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM bus owner shared by instruction fetch and load/store ports
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              instEn,
  input  logic [ADDR_W-1:0] instAddr,
  input  logic              misTaken,
  output logic              memInstOutEn,
  output logic [31:0]       memInst,
  input  logic              dataEn,
  input  logic              dataWr,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [1:0]        dataLen,
  input  logic [31:0]       dataIn,
  output logic              dataOutEn,
  output logic [31:0]       dataOut,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]        state;
  logic [1:0]        k;
  logic [1:0]        cur_len;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic              cur_inst;
  logic [23:0]       rbuf;

  logic              inst_pend;
  logic [ADDR_W-1:0] inst_pend_addr;
  logic              data_pend;
  logic              data_pend_wr;
  logic [ADDR_W-1:0] data_pend_addr;
  logic [1:0]        data_pend_len;
  logic [31:0]       data_pend_wdata;
  logic              inst_done;

  logic              inst_req;
  logic              data_req;
  logic [ADDR_W-1:0] inst_req_addr;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_len;
  logic [31:0]       req_wdata;
  logic              inst_kill;
  logic [31:0]       assembled;
  logic [7:0]        wr_byte;

  // A mispredict makes any instruction request in flight or arriving this cycle stale.
  assign inst_req      = (inst_pend | instEn) & ~misTaken;
  assign inst_req_addr = instEn ? instAddr : inst_pend_addr;
  assign data_req      = data_pend | dataEn;
  assign inst_kill     = cur_inst & misTaken;

  always_comb begin
    req_wr    = data_pend_wr;
    req_addr  = data_pend_addr;
    req_len   = data_pend_len;
    req_wdata = data_pend_wdata;
    if (dataEn) begin
      req_wr    = dataWr;
      req_addr  = dataAddr;
      req_len   = dataLen;
      req_wdata = dataIn;
    end
  end

  // The last byte arrives on mem_din during FINISH and is merged without a register stage.
  always_comb begin
    assembled = {8'h00, rbuf};
    case (cur_len)
      2'd0:    assembled[7:0]   = mem_din;
      2'd1:    assembled[15:8]  = mem_din;
      2'd2:    assembled[23:16] = mem_din;
      default: assembled[31:24] = mem_din;
    endcase
  end

  always_comb begin
    wr_byte = 8'h00;
    case (k)
      2'd0:    wr_byte = cur_wdata[7:0];
      2'd1:    wr_byte = cur_wdata[15:8];
      2'd2:    wr_byte = cur_wdata[23:16];
      default: wr_byte = cur_wdata[31:24];
    endcase
  end

  assign mem_a        = (state == S_READ || state == S_WRITE)
                        ? cur_addr + {{(ADDR_W-2){1'b0}}, k} : '0;
  assign mem_wr       = (state == S_WRITE);
  assign mem_dout     = mem_wr ? wr_byte : 8'h00;
  assign memInstOutEn = inst_done & ~misTaken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      k               <= 2'd0;
      cur_len         <= 2'd0;
      cur_addr        <= '0;
      cur_wdata       <= 32'h0;
      cur_inst        <= 1'b0;
      rbuf            <= 24'h0;
      inst_pend       <= 1'b0;
      inst_pend_addr  <= '0;
      data_pend       <= 1'b0;
      data_pend_wr    <= 1'b0;
      data_pend_addr  <= '0;
      data_pend_len   <= 2'd0;
      data_pend_wdata <= 32'h0;
      inst_done       <= 1'b0;
      memInst         <= 32'h0;
      dataOutEn       <= 1'b0;
      dataOut         <= 32'h0;
    end else if (rdy) begin
      inst_done <= 1'b0;
      dataOutEn <= 1'b0;

      if (instEn && !misTaken) begin
        inst_pend      <= 1'b1;
        inst_pend_addr <= instAddr;
      end
      if (misTaken) begin
        inst_pend <= 1'b0;
      end
      if (dataEn) begin
        data_pend       <= 1'b1;
        data_pend_wr    <= dataWr;
        data_pend_addr  <= dataAddr;
        data_pend_len   <= dataLen;
        data_pend_wdata <= dataIn;
      end

      case (state)
        S_IDLE: begin
          k    <= 2'd0;
          rbuf <= 24'h0;
          if (data_req) begin
            data_pend <= 1'b0;
            cur_inst  <= 1'b0;
            cur_addr  <= req_addr;
            cur_len   <= req_len;
            cur_wdata <= req_wdata;
            state     <= req_wr ? S_WRITE : S_READ;
          end else if (inst_req) begin
            inst_pend <= 1'b0;
            cur_inst  <= 1'b1;
            cur_addr  <= inst_req_addr;
            cur_len   <= 2'd3;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (inst_kill) begin
            state <= S_IDLE;
          end else begin
            // mem_din now carries the byte addressed in the previous cycle.
            case (k)
              2'd1:    rbuf[7:0]   <= mem_din;
              2'd2:    rbuf[15:8]  <= mem_din;
              2'd3:    rbuf[23:16] <= mem_din;
              default: ;
            endcase
            if (k == cur_len) begin
              state <= S_FINISH;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        S_WRITE: begin
          if (k == cur_len) begin
            state     <= S_IDLE;
            dataOutEn <= 1'b1;
          end else begin
            k <= k + 2'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          if (cur_inst) begin
            if (!misTaken) begin
              inst_done <= 1'b1;
              memInst   <= assembled;
            end
          end else begin
            dataOutEn <= 1'b1;
            dataOut   <= assembled;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed and randomized checks of mem_ctrl against a byte-array memory model
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        instEn = 1'b0;
  logic        misTaken = 1'b0;
  logic        dataEn = 1'b0;
  logic        dataWr = 1'b0;
  logic [31:0] instAddr = 32'h0;
  logic [31:0] dataAddr = 32'h0;
  logic [31:0] dataIn = 32'h0;
  logic [1:0]  dataLen = 2'd0;
  logic        memInstOutEn;
  logic        dataOutEn;
  logic        mem_wr;
  logic [31:0] memInst;
  logic [31:0] dataOut;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .instEn(instEn), .instAddr(instAddr), .misTaken(misTaken),
    .memInstOutEn(memInstOutEn), .memInst(memInst),
    .dataEn(dataEn), .dataWr(dataWr), .dataAddr(dataAddr), .dataLen(dataLen), .dataIn(dataIn),
    .dataOutEn(dataOutEn), .dataOut(dataOut),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
  );

  // RAM device: registered read, clock-enabled by rdy; unwritten bytes follow init_byte.
  logic [7:0] ram   [0:65535];
  bit         wrote [0:65535];
  logic [7:0] gold  [bit [31:0]];

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ram_rd(logic [31:0] a);
    return wrote[a[15:0]] ? ram[a[15:0]] : init_byte(a);
  endfunction

  function automatic logic [7:0] gold_rd(logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] gold_read(logic [31:0] a, int n);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = gold_rd(32'(a + i));
    return v;
  endfunction

  function automatic void gold_write(logic [31:0] a, int n, logic [31:0] d);
    for (int i = 0; i < n; i++) gold[32'(a + i)] = d[8*i +: 8];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdy) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr) begin
        ram[mem_a[15:0]]   <= mem_dout;
        wrote[mem_a[15:0]] <= 1'b1;
      end
    end
  end

  logic        l_ie [0:4095];
  logic        l_de [0:4095];
  logic        l_wr [0:4095];
  logic [31:0] l_mi [0:4095];
  logic [31:0] l_do [0:4095];
  logic [31:0] l_ma [0:4095];
  logic [7:0]  l_md [0:4095];

  always @(negedge clk) begin
    if (cyc < 4096) begin
      l_ie[cyc] <= memInstOutEn;
      l_de[cyc] <= dataOutEn;
      l_wr[cyc] <= mem_wr;
      l_mi[cyc] <= memInst;
      l_do[cyc] <= dataOut;
      l_ma[cyc] <= mem_a;
      l_md[cyc] <= mem_dout;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int c);
    while (cyc <= c) tick();
  endtask

  function automatic int first_pulse(bit data_port, int from, int to);
    for (int c = from; c <= to && c < 4096; c++)
      if ((data_port ? l_de[c] : l_ie[c]) === 1'b1) return c;
    return -1;
  endfunction

  function automatic int count_pulses(bit data_port, int from, int to);
    int n;
    n = 0;
    for (int c = from; c <= to && c < 4096; c++)
      if ((data_port ? l_de[c] : l_ie[c]) === 1'b1) n++;
    return n;
  endfunction

  // Issue one request in the current cycle and check timing, bus cycles and result.
  task automatic op(input bit isi, input bit wr, input logic [31:0] a, input logic [1:0] len,
                    input logic [31:0] d, input string tag, output int dn);
    int t0, n, f;
    logic [31:0] exp;
    n = isi ? 4 : int'(len) + 1;
    exp = wr ? 32'h0 : gold_read(a, n);
    if (wr) gold_write(a, n, d);
    t0 = cyc;
    if (isi) begin
      instEn = 1'b1; instAddr = a;
    end else begin
      dataEn = 1'b1; dataWr = wr; dataAddr = a; dataLen = len; dataIn = d;
    end
    tick();
    instEn = 1'b0; dataEn = 1'b0;
    dn = t0 + n + (wr ? 1 : 2);
    run_until(dn + 1);
    f = first_pulse(!isi, t0, dn + 1);
    chk({tag, "_done_cycle"}, 32'(f - t0), 32'(dn - t0));
    chk({tag, "_pulses"}, 32'(count_pulses(!isi, t0, dn + 1)), 32'd1);
    if (!wr) chk({tag, "_data"}, isi ? l_mi[dn] : l_do[dn], exp);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_mem_a"}, l_ma[t0 + 1 + k], 32'(a + k));
      chk({tag, "_mem_wr"}, 32'(l_wr[t0 + 1 + k]), 32'(wr));
      if (wr) chk({tag, "_mem_dout"}, 32'(l_md[t0 + 1 + k]), 32'(d[8*k +: 8]));
    end
  endtask

  initial begin
    int t0, dc;
    logic [31:0] w200, d, a;
    logic [1:0] len;
    bit isi, wr;
    string tag;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_inst_en", 32'(memInstOutEn), 32'd0);
    chk("rst_data_en", 32'(dataOutEn), 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_mem_inst", memInst, 32'h0);
    chk("rst_data_out", dataOut, 32'h0);
    rst = 1'b0;
    tick();

    op(1'b0, 1'b1, 32'h100, 2'd3, 32'h00000513, "pre_inst", dc);
    w200 = $urandom;
    op(1'b0, 1'b1, 32'h200, 2'd3, w200, "pre_w200", dc);
    op(1'b1, 1'b0, 32'h100, 2'd3, 32'h0, "ifetch", dc);
    chk("ifetch_lit", l_mi[dc], 32'h00000513);
    op(1'b0, 1'b1, 32'h2000, 2'd3, 32'hDEADBEEF, "st_word", dc);
    op(1'b0, 1'b0, 32'h2000, 2'd3, 32'h0, "ld_word", dc);
    chk("ld_word_lit", l_do[dc], 32'hDEADBEEF);
    op(1'b0, 1'b0, 32'h2001, 2'd0, 32'h0, "ld_byte", dc);
    chk("ld_byte_lit", l_do[dc], 32'h000000BE);
    op(1'b0, 1'b0, 32'hFFFFFFFE, 2'd3, 32'h0, "ld_wrap", dc);

    // Same-cycle contention: load wins, fetch queued behind it.
    t0 = cyc;
    instEn = 1'b1; instAddr = 32'h100;
    dataEn = 1'b1; dataWr = 1'b0; dataAddr = 32'h2000; dataLen = 2'd1;
    tick();
    instEn = 1'b0; dataEn = 1'b0;
    run_until(t0 + 11);
    chk("cont_data_cycle", 32'(first_pulse(1'b1, t0, t0 + 11) - t0), 32'd4);
    chk("cont_data_val", l_do[t0 + 4], 32'h0000BEEF);
    chk("cont_mem_a1", l_ma[t0 + 1], 32'h2000);
    chk("cont_mem_a2", l_ma[t0 + 2], 32'h2001);
    for (int k = 0; k < 4; k++) chk("cont_inst_mem_a", l_ma[t0 + 5 + k], 32'(32'h100 + k));
    chk("cont_inst_cycle", 32'(first_pulse(1'b0, t0, t0 + 11) - t0), 32'd10);
    chk("cont_inst_val", l_mi[t0 + 10], gold_read(32'h100, 4));

    // Fetch request arriving in the cycle a load completes.
    t0 = cyc;
    dataEn = 1'b1; dataWr = 1'b0; dataAddr = 32'h2001; dataLen = 2'd0;
    tick();
    dataEn = 1'b0;
    run_until(t0 + 2);
    instEn = 1'b1; instAddr = 32'h200;
    tick();
    instEn = 1'b0;
    run_until(t0 + 11);
    chk("dq_data_cycle", 32'(first_pulse(1'b1, t0, t0 + 11) - t0), 32'd3);
    chk("dq_mem_a", l_ma[t0 + 4], 32'h200);
    chk("dq_inst_cycle", 32'(first_pulse(1'b0, t0, t0 + 11) - t0), 32'd9);
    chk("dq_inst_val", l_mi[t0 + 9], w200);

    // Mispredict during a fetch, then a fresh fetch.
    t0 = cyc;
    instEn = 1'b1; instAddr = 32'h100;
    tick();
    instEn = 1'b0;
    run_until(t0 + 2);
    misTaken = 1'b1;
    tick();
    misTaken = 1'b0;
    instEn = 1'b1; instAddr = 32'h200;
    tick();
    instEn = 1'b0;
    run_until(t0 + 12);
    chk("mis_idle_mem_a", l_ma[t0 + 4], 32'h0);
    chk("mis_no_pulse", 32'(count_pulses(1'b0, t0, t0 + 9)), 32'd0);
    chk("mis_new_mem_a", l_ma[t0 + 5], 32'h200);
    chk("mis_new_cycle", 32'(first_pulse(1'b0, t0, t0 + 12) - t0), 32'd10);
    chk("mis_new_val", l_mi[t0 + 10], w200);

    // Mispredict in the very cycle the fetch result would be signalled.
    t0 = cyc;
    instEn = 1'b1; instAddr = 32'h100;
    tick();
    instEn = 1'b0;
    run_until(t0 + 5);
    misTaken = 1'b1;
    tick();
    misTaken = 1'b0;
    run_until(t0 + 9);
    chk("mis_done_suppr", 32'(count_pulses(1'b0, t0, t0 + 9)), 32'd0);

    // rdy low for cycles 2-4 of a fetch.
    t0 = cyc;
    instEn = 1'b1; instAddr = 32'h100;
    tick();
    instEn = 1'b0;
    tick();
    rdy = 1'b0;
    run_until(t0 + 4);
    rdy = 1'b1;
    run_until(t0 + 11);
    for (int c = 2; c <= 5; c++) chk("stall_mem_a_hold", l_ma[t0 + c], 32'h101);
    chk("stall_mem_a_next", l_ma[t0 + 6], 32'h102);
    chk("stall_inst_cycle", 32'(first_pulse(1'b0, t0, t0 + 11) - t0), 32'd9);
    chk("stall_pulses", 32'(count_pulses(1'b0, t0, t0 + 11)), 32'd1);
    chk("stall_inst_val", l_mi[t0 + 9], 32'h00000513);

    // Reset in cycle 2 of a word store.
    t0 = cyc;
    dataEn = 1'b1; dataWr = 1'b1; dataAddr = 32'h3000; dataLen = 2'd3; dataIn = $urandom;
    tick();
    dataEn = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_until(t0 + 8);
    chk("rst_mid_mem_wr", 32'(l_wr[t0 + 3]), 32'd0);
    chk("rst_mid_no_done", 32'(count_pulses(1'b1, t0, t0 + 8)), 32'd0);
    chk("rst_mid_data_out", dataOut, 32'h0);
    chk("rst_mid_mem_inst", memInst, 32'h0);

    for (int i = 0; i < 24; i++) begin
      isi = ($urandom_range(0, 3) == 0);
      wr = !isi && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0: len = 2'd0;
        1: len = 2'd1;
        default: len = 2'd3;
      endcase
      if (isi) len = 2'd3;
      a = 32'h4000 + 32'($urandom_range(0, 255));
      d = $urandom;
      if (isi) tag = "rnd_inst";
      else if (wr) tag = "rnd_store";
      else tag = "rnd_load";
      op(isi, wr, a, len, d, tag, dc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
